// File: rtl/tie_queue_param_if.sv
// TIE queue bundle between a core's TIE_OUTQ1/TIE_INQ1 pins and the loopback queue.
// master = core side, slave = queue side.
interface tie_queue_param_if #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNTW = $clog2(DEPTH) + 1;

    logic             TIE_QUEUE_Flush;
    logic             TIE_OUTQ1_PushReq;
    logic [WIDTH-1:0] TIE_OUTQ1;
    logic             TIE_OUTQ1_Full;
    logic             TIE_INQ1_PopReq;
    logic [WIDTH-1:0] TIE_INQ1;
    logic             TIE_INQ1_Empty;
    logic [CNTW-1:0]  TIE_QUEUE_Count;
    logic             TIE_QUEUE_AlmostFull;
    logic             TIE_QUEUE_Overflow;
    logic             TIE_QUEUE_Underflow;

    modport master (
        output TIE_QUEUE_Flush, TIE_OUTQ1_PushReq, TIE_OUTQ1, TIE_INQ1_PopReq,
        input  TIE_OUTQ1_Full, TIE_INQ1, TIE_INQ1_Empty, TIE_QUEUE_Count,
               TIE_QUEUE_AlmostFull, TIE_QUEUE_Overflow, TIE_QUEUE_Underflow
    );

    modport slave (
        input  TIE_QUEUE_Flush, TIE_OUTQ1_PushReq, TIE_OUTQ1, TIE_INQ1_PopReq,
        output TIE_OUTQ1_Full, TIE_INQ1, TIE_INQ1_Empty, TIE_QUEUE_Count,
               TIE_QUEUE_AlmostFull, TIE_QUEUE_Overflow, TIE_QUEUE_Underflow
    );
endinterface

// File: rtl/tie_queue_param.sv
// Parametrised TIE loopback queue (show-ahead FIFO) with count, almost-full, flush and sticky error flags.
// Optional I/O trace printing enabled by defining TIE_QUEUE_DISPLAY_IO_EN.
module tie_queue_param #(
    parameter int unsigned WIDTH    = 96,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AF_LEVEL = DEPTH - 1
) (
    input logic              CLK,
    input logic              RST_N,
    tie_queue_param_if.slave q
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CNTW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [CNTW-1:0]  count;
    logic             overflow;
    logic             underflow;

    logic full_c;
    logic empty_c;
    logic push_ok_c;
    logic pop_ok_c;

    // Status is derived purely from the registered count, never bypassed.
    assign full_c    = (count == CNTW'(DEPTH));
    assign empty_c   = (count == '0);
    assign push_ok_c = q.TIE_OUTQ1_PushReq && !full_c;
    assign pop_ok_c  = q.TIE_INQ1_PopReq && !empty_c;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            store[0]  <= '0;
        end else if (q.TIE_QUEUE_Flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push_ok_c) begin
                store[wp] <= q.TIE_OUTQ1;
                wp        <= wp + AW'(1);
            end
            if (pop_ok_c) begin
                rp <= rp + AW'(1);
            end
            if (push_ok_c && !pop_ok_c) begin
                count <= count + CNTW'(1);
            end else if (pop_ok_c && !push_ok_c) begin
                count <= count - CNTW'(1);
            end
            if (q.TIE_OUTQ1_PushReq && full_c) begin
                overflow <= 1'b1;
            end
            if (q.TIE_INQ1_PopReq && empty_c) begin
                underflow <= 1'b1;
            end
        end
    end

    assign q.TIE_OUTQ1_Full       = full_c;
    assign q.TIE_INQ1_Empty       = empty_c;
    assign q.TIE_QUEUE_Count      = count;
    assign q.TIE_QUEUE_AlmostFull = (count >= CNTW'(AF_LEVEL));
    assign q.TIE_QUEUE_Overflow   = overflow;
    assign q.TIE_QUEUE_Underflow  = underflow;
    assign q.TIE_INQ1             = store[rp];

`ifdef TIE_QUEUE_DISPLAY_IO_EN
    // Trace of accepted pushes and refused requests, sampled like the state update.
    always @(posedge CLK) begin
        if (RST_N && !q.TIE_QUEUE_Flush) begin
            if (push_ok_c) begin
                $display("%t TIE_OUTQ1 = 0x%h", $time, q.TIE_OUTQ1);
            end
            if (q.TIE_OUTQ1_PushReq && full_c) begin
                $display("%t TIE_QUEUE overflow", $time);
            end
            if (q.TIE_INQ1_PopReq && empty_c) begin
                $display("%t TIE_QUEUE underflow", $time);
            end
        end
    end

    always @(q.TIE_INQ1) begin
        $display("%t TIE_INQ1  = 0x%h", $time, q.TIE_INQ1);
    end
`else
    // Silent build: no simulation output.
`endif

endmodule

// File: tb/tb_tie_queue_param.sv
// Self-checking bench for tie_queue_param: a 4x96 and a 16x8 (AF_LEVEL=12) instance
// checked against a queue-based reference model with directed and random traffic.
module tb_tie_queue_param;
    logic CLK = 1'b0;
    logic rst_a;
    logic rst_b;

    tie_queue_param_if                          ifa ();
    tie_queue_param_if #(.WIDTH(8), .DEPTH(16)) ifb ();

    tie_queue_param u_a (
        .CLK  (CLK),
        .RST_N(rst_a),
        .q    (ifa)
    );

    tie_queue_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12)) u_b (
        .CLK  (CLK),
        .RST_N(rst_b),
        .q    (ifb)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [95:0] qa[$];
    logic [95:0] qb[$];
    bit          ovf[2];
    bit          udf[2];
    bit          head_zero[2];
    int          depth_of[2] = '{4, 16};
    int          af_of[2]    = '{3, 12};

    task automatic check(input string tag, input int d, input logic [95:0] obs,
                         input logic [95:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s[%0d]: observed 0x%0h expected 0x%0h", tag, d, obs, exp);
        end
    endtask

    task automatic idle_all();
        ifa.TIE_QUEUE_Flush   = 1'b0;
        ifa.TIE_OUTQ1_PushReq = 1'b0;
        ifa.TIE_INQ1_PopReq   = 1'b0;
        ifa.TIE_OUTQ1         = '0;
        ifb.TIE_QUEUE_Flush   = 1'b0;
        ifb.TIE_OUTQ1_PushReq = 1'b0;
        ifb.TIE_INQ1_PopReq   = 1'b0;
        ifb.TIE_OUTQ1         = '0;
        rst_a                 = 1'b1;
        rst_b                 = 1'b1;
    endtask

    // One clock of stimulus on instance d, followed by a full output check.
    task automatic step(input int d, input bit push, input bit pop, input bit flush,
                        input bit rstn, input logic [95:0] data);
        logic [95:0] dm;
        logic [95:0] head;
        int          sz;
        bit          full;
        bit          empty;
        logic [95:0] o_cnt, o_full, o_empty, o_af, o_ovf, o_udf, o_data;

        dm = (d == 1) ? {88'b0, data[7:0]} : data;
        idle_all();
        if (d == 0) begin
            ifa.TIE_OUTQ1_PushReq = push;
            ifa.TIE_INQ1_PopReq   = pop;
            ifa.TIE_QUEUE_Flush   = flush;
            ifa.TIE_OUTQ1         = data;
            rst_a                 = rstn;
            sz                    = qa.size();
        end else begin
            ifb.TIE_OUTQ1_PushReq = push;
            ifb.TIE_INQ1_PopReq   = pop;
            ifb.TIE_QUEUE_Flush   = flush;
            ifb.TIE_OUTQ1         = data[7:0];
            rst_b                 = rstn;
            sz                    = qb.size();
        end
        full  = (sz == depth_of[d]);
        empty = (sz == 0);

        @(posedge CLK);
        #1;

        if (!rstn) begin
            if (d == 0) qa.delete(); else qb.delete();
            ovf[d]       = 1'b0;
            udf[d]       = 1'b0;
            head_zero[d] = 1'b1;
        end else if (flush) begin
            if (d == 0) qa.delete(); else qb.delete();
            head_zero[d] = 1'b0;
        end else begin
            if (push && full)  ovf[d] = 1'b1;
            if (pop && empty)  udf[d] = 1'b1;
            if (pop && !empty) begin
                if (d == 0) void'(qa.pop_front()); else void'(qb.pop_front());
            end
            if (push && !full) begin
                if (d == 0) qa.push_back(dm); else qb.push_back(dm);
                head_zero[d] = 1'b0;
            end
        end

        if (d == 0) begin
            sz      = qa.size();
            head    = (sz > 0) ? qa[0] : '0;
            o_cnt   = 96'(ifa.TIE_QUEUE_Count);
            o_full  = 96'(ifa.TIE_OUTQ1_Full);
            o_empty = 96'(ifa.TIE_INQ1_Empty);
            o_af    = 96'(ifa.TIE_QUEUE_AlmostFull);
            o_ovf   = 96'(ifa.TIE_QUEUE_Overflow);
            o_udf   = 96'(ifa.TIE_QUEUE_Underflow);
            o_data  = ifa.TIE_INQ1;
        end else begin
            sz      = qb.size();
            head    = (sz > 0) ? qb[0] : '0;
            o_cnt   = 96'(ifb.TIE_QUEUE_Count);
            o_full  = 96'(ifb.TIE_OUTQ1_Full);
            o_empty = 96'(ifb.TIE_INQ1_Empty);
            o_af    = 96'(ifb.TIE_QUEUE_AlmostFull);
            o_ovf   = 96'(ifb.TIE_QUEUE_Overflow);
            o_udf   = 96'(ifb.TIE_QUEUE_Underflow);
            o_data  = 96'(ifb.TIE_INQ1);
        end

        check("count",      d, o_cnt,   96'(sz));
        check("full",       d, o_full,  96'(sz == depth_of[d]));
        check("empty",      d, o_empty, 96'(sz == 0));
        check("almostfull", d, o_af,    96'(sz >= af_of[d]));
        check("overflow",   d, o_ovf,   96'(ovf[d]));
        check("underflow",  d, o_udf,   96'(udf[d]));
        if (sz > 0) begin
            check("inq1", d, o_data, head);
        end else if (head_zero[d]) begin
            check("inq1_rst", d, o_data, 96'(0));
        end
    endtask

    initial begin
        int bias;
        idle_all();
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Reset values on both instances.
        step(0, 1'b0, 1'b0, 1'b0, 1'b0, 96'h0);
        step(1, 1'b0, 1'b0, 1'b0, 1'b0, 96'h0);

        // Fill the 4-deep queue: count 1..4, AlmostFull at 3, Full at 4, head stays 0x1.
        for (int i = 1; i <= 4; i++) step(0, 1'b1, 1'b0, 1'b0, 1'b1, 96'(i));

        // Push while full with a pop: pop taken, 0x5 dropped, overflow set.
        step(0, 1'b1, 1'b1, 1'b0, 1'b1, 96'h5);
        for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b1, 1'b0, 1'b1, 96'h0);

        // Empty queue, push 0xA with pop: push only, underflow set.
        step(0, 1'b1, 1'b1, 1'b0, 1'b1, 96'hA);
        step(0, 1'b1, 1'b0, 1'b0, 1'b1, 96'hB);

        // Count=2, sustained push+pop across pointer wrap.
        for (int i = 0; i < 10; i++) step(0, 1'b1, 1'b1, 1'b0, 1'b1, 96'(32'h20 + i));

        // Count=3, flush with push, then reset mid-traffic.
        step(0, 1'b1, 1'b0, 1'b0, 1'b1, 96'hC);
        step(0, 1'b1, 1'b0, 1'b1, 1'b1, 96'hD);
        step(0, 1'b1, 1'b0, 1'b0, 1'b1, 96'hE);
        step(0, 1'b1, 1'b1, 1'b0, 1'b1, 96'hF);
        step(0, 1'b1, 1'b1, 1'b0, 1'b0, 96'h10);

        // 16x8 instance: fill, drain in order, one extra pop.
        for (int i = 0; i < 16; i++) step(1, 1'b1, 1'b0, 1'b0, 1'b1, 96'($urandom));
        step(1, 1'b1, 1'b0, 1'b0, 1'b1, 96'h77);
        for (int i = 0; i < 17; i++) step(1, 1'b0, 1'b1, 1'b0, 1'b1, 96'h0);

        // Random traffic with shifting push bias, rare flush and reset.
        for (int i = 0; i < 600; i++) begin
            int d;
            bit push, pop, flush, rstn;
            case ((i / 40) % 3)
                0:       bias = 80;
                1:       bias = 20;
                default: bias = 50;
            endcase
            d     = i % 2;
            push  = ($urandom_range(0, 99) < bias);
            pop   = ($urandom_range(0, 99) < (100 - bias));
            flush = ($urandom_range(0, 39) == 0);
            rstn  = ($urandom_range(0, 99) != 0);
            step(d, push, pop, flush, rstn, {$urandom, $urandom, $urandom});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tie_queue_param.md
# tie_queue_param

Parametrised TIE queue model connecting a core's output queue (TIE_OUTQ1) to its input queue (TIE_INQ1) in Verilog/XTSC co-simulation. It generalises the fixed 4×96-bit loopback queue with configurable width and depth, an occupancy count, an almost-full flag, a synchronous flush and reset. It sits between the processor's TIE queue interface pins and the co-simulation testbench.

## Interface
- WIDTH, 96: data width in bits of queue entries.
- DEPTH, 4: number of entries; power of two, 2..256.
- AF_LEVEL, DEPTH-1: TIE_QUEUE_AlmostFull asserts when count >= AF_LEVEL; range 1..DEPTH.
- CNTW, $clog2(DEPTH)+1: count width; derived, not overridden.

- CLK  in  1  clock, all state on rising edge.
- RST_N  in  1  synchronous, active-low reset.
- TIE_QUEUE_Flush  in  1  synchronous flush, discards contents.
- TIE_OUTQ1_PushReq  in  1  push request from core.
- TIE_OUTQ1  in  WIDTH  push data.
- TIE_OUTQ1_Full  out  1  queue full, push refused.
- TIE_INQ1_PopReq  in  1  pop request from core.
- TIE_INQ1  out  WIDTH  head-of-queue data (show-ahead).
- TIE_INQ1_Empty  out  1  queue empty, pop refused.
- TIE_QUEUE_Count  out  CNTW  current occupancy, 0..DEPTH.
- TIE_QUEUE_AlmostFull  out  1  count >= AF_LEVEL.
- TIE_QUEUE_Overflow  out  1  sticky: push attempted while full.
- TIE_QUEUE_Underflow  out  1  sticky: pop attempted while empty.

## Operation
- State: wp, rp (log2(DEPTH) bits, wrap DEPTH-1 -> 0), count (CNTW bits), storage DEPTH×WIDTH.
- Push accepted = PushReq && !Full; writes store[wp], wp+1.
- Pop accepted = PopReq && !Empty; rp+1.
- Both accepted in the same cycle: count unchanged, both pointers advance.
- Push while full is refused even if a pop is accepted that cycle; pop while empty is refused even if a push is accepted that cycle (flags are registered state, not bypassed).
- Full = (count == DEPTH); Empty = (count == 0); AlmostFull = (count >= AF_LEVEL). All three are derived from registered count only.
- TIE_INQ1 = store[rp], combinational from registers.
- Priority per edge: RST_N low > Flush > push/pop.
- Flush: wp, rp, count <- 0; storage untouched; Overflow/Underflow retained; push/pop in the same cycle ignored.
- Reset: wp = rp = count = 0; store[0] = 0; Overflow = Underflow = 0. Other storage entries are not reset.
- Output reset values: Full 0, Empty 1, Count 0, AlmostFull 0 (AF_LEVEL >= 1), TIE_INQ1 = 0, Overflow 0, Underflow 0.

## Timing
- Push at edge N: the word is at TIE_INQ1 (if it was the only entry), Empty = 0, and Count has incremented after edge N.
- Pop at edge N: the next entry is presented after edge N.
- Minimum latency from push to poppable is 1 cycle. There is no fall-through in the same cycle.
- Full asserts on the edge that accepts the DEPTH-th entry. It deasserts on the edge of the first accepted pop.
- Sticky flags set on the edge where the illegal request is sampled, and hold until reset.
- Throughput: one push and one pop per cycle, sustained, at any occupancy 1..DEPTH-1.

## Configuration
- TIE_QUEUE_DISPLAY_IO_EN defined:
  - $display prints "%t TIE_OUTQ1 = 0x%h" for every accepted push.
  - $display prints "%t TIE_INQ1  = 0x%h" on every change of TIE_INQ1.
  - "%t TIE_QUEUE overflow" / "underflow" is printed on each refused request.
- Not defined: no simulation output. Functional behaviour is identical in both cases.

## Test plan
- Reset, then DEPTH=4, WIDTH=96: push 0x1, 0x2, 0x3, 0x4 on consecutive cycles -> Count 1,2,3,4; Full=1 after the 4th edge; AlmostFull=1 after the 3rd; TIE_INQ1=0x1 throughout.
- Queue full, push 0x5 with pop -> pop accepted, 0x5 dropped, Count=3, Overflow=1; pops then return 0x2, 0x3, 0x4; Empty=1.
- Empty queue, simultaneous push 0xA and pop -> push only, Count=1, Underflow=1, TIE_INQ1=0xA next cycle.
- Count=2, simultaneous push/pop for 10 cycles with incrementing data -> Count stays 2; output order is strictly FIFO across pointer wrap.
- Count=3, assert Flush with push -> Count=0, Empty=1, push ignored; sticky flags unchanged. Then RST_N=0 for one edge mid-traffic -> all outputs at reset values after that edge.
- DEPTH=16, WIDTH=8, AF_LEVEL=12: fill to 16 -> AlmostFull at Count=12, Full at 16; drain returns the 16 bytes in order.
